// File: rtl/led_state_seg7_pkg.sv
// Shared definitions for the traffic-light output stage: light state encodings
// and the active-low 7-segment hex patterns (segment order {g,f,e,d,c,b,a}).
package led_state_seg7_pkg;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_RED     = 2'd2,
        ST_ILLEGAL = 2'd3
    } light_state_t;

    // Patterns are stored active-low: a 0 bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    // Any digit that is not a clean 0..F (e.g. carrying X) falls to the blank pattern.
    function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
        case (digit)
            4'h0:    return SEG_HEX_0;
            4'h1:    return SEG_HEX_1;
            4'h2:    return SEG_HEX_2;
            4'h3:    return SEG_HEX_3;
            4'h4:    return SEG_HEX_4;
            4'h5:    return SEG_HEX_5;
            4'h6:    return SEG_HEX_6;
            4'h7:    return SEG_HEX_7;
            4'h8:    return SEG_HEX_8;
            4'h9:    return SEG_HEX_9;
            4'hA:    return SEG_HEX_A;
            4'hB:    return SEG_HEX_B;
            4'hC:    return SEG_HEX_C;
            4'hD:    return SEG_HEX_D;
            4'hE:    return SEG_HEX_E;
            4'hF:    return SEG_HEX_F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/led_state_seg7_lut_core.sv
// seg7_lut_core: combinational hex digit to 7-segment pattern, with the
// output polarity selected by SEG_ACTIVE_LOW.
module seg7_lut_core
    import led_state_seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    logic [6:0] patternLow;

    assign patternLow = seg_lookup(digit_i);
    assign seg_o      = SEG_ACTIVE_LOW ? patternLow : ~patternLow;

endmodule

// File: rtl/led_state_seg7.sv
// led_state_seg7: registered lamp drives with flashing-red fail-safe plus a hex
// display driver. Define SEG7_REG_EN to register oSEG (latency 1, reset to blank).
module led_state_seg7
    import led_state_seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [3:0] iDIG,
    output logic       LEDG,
    output logic [1:0] LEDR,
    output logic [6:0] oSEG
);

    logic       ledg_d, ledg_q;
    logic [1:0] ledr_d, ledr_q;
    logic       illegal_d, illegal_q;
    logic [6:0] segPattern;

    // illegal_q remembers that the previous cycle was already flashing, so the
    // first illegal cycle always starts with the red lamp lit.
    always_comb begin
        ledg_d    = 1'b0;
        ledr_d    = 2'b00;
        illegal_d = 1'b0;
        case (light_state_t'(state))
            ST_GREEN:   ledg_d = 1'b1;
            ST_YELLOW:  ledr_d = 2'b01;
            ST_RED:     ledr_d = 2'b10;
            ST_ILLEGAL: begin
                illegal_d = 1'b1;
                ledr_d    = {(illegal_q ? ~ledr_q[1] : 1'b1), 1'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ledg_q    <= 1'b0;
            ledr_q    <= 2'b00;
            illegal_q <= 1'b0;
        end else begin
            ledg_q    <= ledg_d;
            ledr_q    <= ledr_d;
            illegal_q <= illegal_d;
        end
    end

    assign LEDG = ledg_q;
    assign LEDR = ledr_q;

    seg7_lut_core #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_seg7_lut_core (
        .digit_i (iDIG),
        .seg_o   (segPattern)
    );

`ifdef SEG7_REG_EN
    logic [6:0] seg_d, seg_q;

    assign seg_d = segPattern;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign oSEG = seg_q;
`else
    assign oSEG = segPattern;
`endif

endmodule

// File: tb/tb_led_state_seg7.sv
// Testbench for led_state_seg7: directed and random steps with a scoreboard of
// expected lamp/segment values, covering both segment polarities.
module tb_led_state_seg7;

    logic       clk;
    logic       rst;
    logic [1:0] state;
    logic [3:0] iDIG;
    logic       LEDG, LEDG1;
    logic [1:0] LEDR, LEDR1;
    logic [6:0] oSEG, oSEG1;

    int passCount  = 0;
    int checkCount = 0;

    logic [2:0] lampQ[$];
    logic [6:0] segQ[$];
    logic [6:0] segInvQ[$];

    logic [6:0] hexTable [16];

    logic modelInIllegal;
    logic modelPhase;

    led_state_seg7 dut (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .iDIG  (iDIG),
        .LEDG  (LEDG),
        .LEDR  (LEDR),
        .oSEG  (oSEG)
    );

    led_state_seg7 #(
        .SEG_ACTIVE_LOW (1'b0)
    ) dutHigh (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .iDIG  (iDIG),
        .LEDG  (LEDG1),
        .LEDR  (LEDR1),
        .oSEG  (oSEG1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    endtask

    function automatic logic [6:0] expectedSeg(input logic [3:0] d);
        if ($isunknown(d)) return 7'h7F;
        return hexTable[d];
    endfunction

    // Drives one step, pushes expectations, then checks after the next rising edge.
    task automatic applyStimulus(input logic r, input logic [1:0] s, input logic [3:0] d);
        logic [2:0] lampExp;
        logic [6:0] segExp;
        rst   = r;
        state = s;
        iDIG  = d;
        if (r) begin
            lampExp        = 3'b0_00;
            modelInIllegal = 1'b0;
        end else begin
            case (s)
                2'd0:    lampExp = 3'b1_00;
                2'd1:    lampExp = 3'b0_01;
                2'd2:    lampExp = 3'b0_10;
                default: begin
                    modelPhase = modelInIllegal ? ~modelPhase : 1'b1;
                    lampExp    = {1'b0, modelPhase, 1'b0};
                end
            endcase
            modelInIllegal = (s == 2'd3);
        end
        lampQ.push_back(lampExp);
`ifdef SEG7_REG_EN
        segExp = r ? 7'h7F : expectedSeg(d);
        segQ.push_back(segExp);
        segInvQ.push_back(~segExp);
`else
        segExp = expectedSeg(d);
        segQ.push_back(segExp);
        segInvQ.push_back(~segExp);
        #1;
        checkOutput("seg_low", oSEG, segQ.pop_front());
        checkOutput("seg_high", oSEG1, segInvQ.pop_front());
`endif
        @(posedge clk);
        #1;
        lampExp = lampQ.pop_front();
        checkOutput("lamps", {4'b0, LEDG, LEDR}, {4'b0, lampExp});
        checkOutput("lamps_high", {4'b0, LEDG1, LEDR1}, {4'b0, lampExp});
        checkOutput("no_green_red", {6'b0, LEDG & LEDR[1]}, 7'd0);
`ifdef SEG7_REG_EN
        checkOutput("seg_low", oSEG, segQ.pop_front());
        checkOutput("seg_high", oSEG1, segInvQ.pop_front());
`endif
    endtask

    initial begin
        hexTable = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                     7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        modelInIllegal = 1'b0;
        modelPhase     = 1'b0;

        applyStimulus(1'b1, 2'd2, 4'h0);
        applyStimulus(1'b1, 2'd2, 4'h1);
        applyStimulus(1'b0, 2'd2, 4'h2);

        applyStimulus(1'b0, 2'd0, 4'h3);
        applyStimulus(1'b0, 2'd1, 4'h4);
        applyStimulus(1'b0, 2'd2, 4'h5);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'd3, 4'h6);
        applyStimulus(1'b0, 2'd0, 4'h7);

        applyStimulus(1'b0, 2'd3, 4'h8);
        applyStimulus(1'b0, 2'd3, 4'h9);
        applyStimulus(1'b1, 2'd3, 4'hA);
        applyStimulus(1'b0, 2'd3, 4'hB);
        applyStimulus(1'b0, 2'd3, 4'hC);
        applyStimulus(1'b0, 2'd1, 4'hD);
        applyStimulus(1'b0, 2'd3, 4'hE);

        for (int d = 0; d < 16; d++) applyStimulus(1'b0, 2'(d % 3), 4'(d));

        applyStimulus(1'b0, 2'd2, 4'h3);
        applyStimulus(1'b0, 2'd2, 4'h8);
        applyStimulus(1'b0, 2'd1, 4'bxxxx);
        applyStimulus(1'b1, 2'd0, 4'hF);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
